mmio_io_unit: RTL

- Memory-mapped I/O unit on the data-memory side, downstream of the execute/memory pipe register.
- Consumes the registered store address, store data and store enable, and drives the board HEX, LEDR and LEDG outputs.
- Synchronises and debounces SW and KEY, and provides sticky KEY press-capture bits.
- Drives a read-data bus plus a hit flag that the writeback data mux uses in place of RAM data.

---
 rtl/mmio_io_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mmio_io_unit.sv
// Memory-mapped board I/O: HEX/LEDR/LEDG output registers, SW/KEY synchronisers, KEY press capture.
// Build option: define MMIO_IO_DEBOUNCE_EN to add per-key debounce counters.
module mmio_io_unit #(
  parameter int                DBITS       = 32,
  parameter logic [DBITS-1:0]  ADDR_HEX    = 32'hF0000000,
  parameter logic [DBITS-1:0]  ADDR_LEDR   = 32'hF0000004,
  parameter logic [DBITS-1:0]  ADDR_LEDG   = 32'hF0000008,
  parameter logic [DBITS-1:0]  ADDR_KEY    = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SW     = 32'hF0000014,
  parameter logic [DBITS-1:0]  ADDR_KEYCAP = 32'hF0000018,
  parameter int                DB_CYCLES   = 50000,
  parameter int                DB_BITS     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] dIn,
  input  logic             wrtEn,
  input  logic [9:0]       sw,
  input  logic [3:0]       key,
  output logic [15:0]      hex,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg,
  output logic [DBITS-1:0] dOut,
  output logic             ioHit
);

  logic [15:0]      hex_r;
  logic [9:0]       ledr_r;
  logic [7:0]       ledg_r;
  logic [9:0]       sw_meta_r;
  logic [9:0]       sw_sync_r;
  logic [3:0]       key_meta_r;
  logic [3:0]       key_sync_r;
  logic [3:0]       key_stable_s;
  logic [3:0]       key_prev_r;
  logic [3:0]       key_cap_r;
  logic [3:0]       key_rise_s;
  logic [3:0]       cap_clr_s;
  logic             wr_hex_s;
  logic             wr_ledr_s;
  logic             wr_ledg_s;
  logic             wr_keycap_s;
  logic [DBITS-1:0] dout_s;
  logic             hit_s;
  logic             unused_din_s;

  assign wr_hex_s    = wrtEn && (addr == ADDR_HEX);
  assign wr_ledr_s   = wrtEn && (addr == ADDR_LEDR);
  assign wr_ledg_s   = wrtEn && (addr == ADDR_LEDG);
  assign wr_keycap_s = wrtEn && (addr == ADDR_KEYCAP);
  assign unused_din_s = ^dIn[DBITS-1:16];

  // Board output registers, loaded by stores to their addresses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_r  <= 16'h0000;
      ledr_r <= 10'h000;
      ledg_r <= 8'h00;
    end else begin
      if (wr_hex_s)  hex_r  <= dIn[15:0];
      if (wr_ledr_s) ledr_r <= dIn[9:0];
      if (wr_ledg_s) ledg_r <= dIn[7:0];
    end
  end

  // Two-flop synchronisers; keys are inverted so pressed reads as 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_r  <= 10'h000;
      sw_sync_r  <= 10'h000;
      key_meta_r <= 4'h0;
      key_sync_r <= 4'h0;
    end else begin
      sw_meta_r  <= sw;
      sw_sync_r  <= sw_meta_r;
      key_meta_r <= ~key;
      key_sync_r <= key_meta_r;
    end
  end

`ifdef MMIO_IO_DEBOUNCE_EN
  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DB_CYCLES - 1);

  logic [DB_BITS-1:0] db_cnt_r [4];
  logic [3:0]         key_stable_r;

  // Per-key stability counter: only a full run of differing samples flips the stable value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_stable_r <= 4'h0;
      for (int i = 0; i < 4; i++) db_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (key_sync_r[i] == key_stable_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          key_stable_r[i] <= key_sync_r[i];
          db_cnt_r[i]     <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + {{(DB_BITS-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign key_stable_s = key_stable_r;
`else
  assign key_stable_s = key_sync_r;
`endif

  // A debounce window wider than the counter elaborates this empty marker scope
  if (((DB_CYCLES - 1) >> DB_BITS) != 0) begin : g_db_cycles_out_of_range
  end

  assign key_rise_s = key_stable_s & ~key_prev_r;
  assign cap_clr_s  = wr_keycap_s ? dIn[3:0] : 4'h0;

  // Sticky press capture; a new press on the clearing edge keeps its bit set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_prev_r <= 4'h0;
      key_cap_r  <= 4'h0;
    end else begin
      key_prev_r <= key_stable_s;
      key_cap_r  <= (key_cap_r & ~cap_clr_s) | key_rise_s;
    end
  end

  // Read mux; exact address compare, anything else reads 0 without a hit
  always_comb begin
    dout_s = '0;
    hit_s  = 1'b0;
    case (addr)
      ADDR_HEX:    begin dout_s = {{(DBITS-16){1'b0}}, hex_r};      hit_s = 1'b1; end
      ADDR_LEDR:   begin dout_s = {{(DBITS-10){1'b0}}, ledr_r};     hit_s = 1'b1; end
      ADDR_LEDG:   begin dout_s = {{(DBITS-8){1'b0}},  ledg_r};     hit_s = 1'b1; end
      ADDR_KEY:    begin dout_s = {{(DBITS-4){1'b0}},  key_stable_s}; hit_s = 1'b1; end
      ADDR_SW:     begin dout_s = {{(DBITS-10){1'b0}}, sw_sync_r};  hit_s = 1'b1; end
      ADDR_KEYCAP: begin dout_s = {{(DBITS-4){1'b0}},  key_cap_r};  hit_s = 1'b1; end
      default:     begin dout_s = '0;                               hit_s = 1'b0; end
    endcase
  end

  assign hex   = hex_r;
  assign ledr  = ledr_r;
  assign ledg  = ledg_r;
  assign dOut  = dout_s;
  assign ioHit = hit_s;

endmodule
